// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller: register index type,
// controller state encoding, the bundle of latch controls and the
// priority resolver used while the pipeline is running.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        MEM_WAIT = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } hzd_state_t;

    // One record per cycle covering the PC, every latch and the halt flag.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exm_en;
        logic mwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exm_flush;
        logic mwb_flush;
        logic halt;
    } hzd_ctrl_t;

    // Reset recovery: hold everything and fill the pipe with bubbles.
    localparam hzd_ctrl_t CTRL_IDLE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exm_en: 1'b0, mwb_en: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1, exm_flush: 1'b1, mwb_flush: 1'b1, halt: 1'b0};
    // HALT reached EX/MEM: freeze it there, squash younger instructions.
    localparam hzd_ctrl_t CTRL_HALT_REQ = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exm_en: 1'b0, mwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exm_flush: 1'b0, mwb_flush: 1'b0, halt: 1'b0};
    // Data memory busy: freeze the front, feed bubbles into MEM/WB.
    localparam hzd_ctrl_t CTRL_MEM_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exm_en: 1'b0, mwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exm_flush: 1'b0, mwb_flush: 1'b1, halt: 1'b0};
    // Taken branch/jump: load the new PC, kill the three younger slots.
    localparam hzd_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exm_en: 1'b1, mwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exm_flush: 1'b1, mwb_flush: 1'b0, halt: 1'b0};
    // Load-use: hold PC and IF/ID one cycle, bubble into ID/EX.
    localparam hzd_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exm_en: 1'b1, mwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1, exm_flush: 1'b0, mwb_flush: 1'b0, halt: 1'b0};
    // Fetch miss: hold PC, bubble into IF/ID, let older work advance.
    localparam hzd_ctrl_t CTRL_FETCH_MISS = '{pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exm_en: 1'b1, mwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b0, exm_flush: 1'b0, mwb_flush: 1'b0, halt: 1'b0};
    localparam hzd_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exm_en: 1'b1, mwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exm_flush: 1'b0, mwb_flush: 1'b0, halt: 1'b0};
    // Drain: only MEM/WB retires; EX/MEM is emptied behind the HALT.
    localparam hzd_ctrl_t CTRL_DRAIN = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exm_en: 1'b0, mwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exm_flush: 1'b1, mwb_flush: 1'b0, halt: 1'b0};
    localparam hzd_ctrl_t CTRL_HALTED = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exm_en: 1'b0, mwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exm_flush: 1'b0, mwb_flush: 1'b0, halt: 1'b1};

    // Running-state priority: halt, memory wait, redirect, load-use, fetch miss.
    // Callers pass mem_busy=0 when the memory wait has just been resolved.
    function automatic hzd_ctrl_t run_ctrl(input logic halt_req, input logic mem_busy,
                                           input logic redirect, input logic lu_hazard,
                                           input logic ihit);
        hzd_ctrl_t c;
        if (halt_req) begin
            c = CTRL_HALT_REQ;
        end else if (mem_busy) begin
            c = CTRL_MEM_STALL;
        end else if (redirect) begin
            c = CTRL_REDIRECT;
        end else if (lu_hazard) begin
            c = CTRL_LOAD_USE;
        end else if (!ihit) begin
            c = CTRL_FETCH_MISS;
        end else begin
            c = CTRL_RUN;
        end
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Detects a load in ID/EX whose destination feeds the instruction in IF/ID.
// Register 0 is never a real dependency.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_dREN,
    input  regbits_t idex_wsel,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_rt_used,
    output logic     lu_hazard
);

    // Compare the load destination against the consumer's source registers.
    always_comb begin
        lu_hazard = idex_dREN && (idex_wsel != 5'd0) &&
                    ((idex_wsel == ifid_rs) || (ifid_rt_used && (idex_wsel == ifid_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: PC/latch enables and flushes for load-use
// bubbles, data-memory freezes, redirect flushes, fetch misses and the
// HALT drain sequence. Outputs are combinational from state and inputs.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_rt_used,
    input  logic     idex_dREN,
    input  regbits_t idex_wsel,
    input  logic     exm_dREN,
    input  logic     exm_dWEN,
    input  logic     exm_pc_redirect,
    input  logic     exm_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     idex_en,
    output logic     exm_en,
    output logic     mwb_en,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exm_flush,
    output logic     mwb_flush,
    output logic     halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    hzd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hzd_ctrl_t        ctrl_s;
    logic             lu_hazard_s;
    logic             mem_busy_s;

    load_use_detect u_lu (
        .idex_dREN    (idex_dREN),
        .idex_wsel    (idex_wsel),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_rt_used (ifid_rt_used),
        .lu_hazard    (lu_hazard_s)
    );

    // A data access in EX/MEM that has not completed this cycle.
    always_comb begin
        mem_busy_s = (exm_dREN || exm_dWEN) && !dhit;
    end

    // State register and drain counter with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and latch-control selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_s  = CTRL_IDLE;
        case (state_q)
            IDLE: begin
                ctrl_s  = CTRL_IDLE;
                state_d = RUN;
            end
            RUN: begin
                ctrl_s = run_ctrl(exm_halt, mem_busy_s, exm_pc_redirect, lu_hazard_s, ihit);
                if (exm_halt) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (mem_busy_s) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                // EX/MEM stays frozen, so a redirect or HALT sitting there is
                // only acted on once the access completes.
                if (!dhit) begin
                    ctrl_s  = CTRL_MEM_STALL;
                    state_d = MEM_WAIT;
                end else begin
                    ctrl_s  = run_ctrl(exm_halt, 1'b0, exm_pc_redirect, lu_hazard_s, ihit);
                    state_d = RUN;
                end
            end
            DRAIN: begin
                ctrl_s = CTRL_DRAIN;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = HALTED;
                end else begin
                    state_d = DRAIN;
                end
            end
            HALTED: begin
                ctrl_s  = CTRL_HALTED;
                state_d = HALTED;
            end
            default: begin
                ctrl_s  = CTRL_IDLE;
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pc_en      = ctrl_s.pc_en;
    assign ifid_en    = ctrl_s.ifid_en;
    assign idex_en    = ctrl_s.idex_en;
    assign exm_en     = ctrl_s.exm_en;
    assign mwb_en     = ctrl_s.mwb_en;
    assign ifid_flush = ctrl_s.ifid_flush;
    assign idex_flush = ctrl_s.idex_flush;
    assign exm_flush  = ctrl_s.exm_flush;
    assign mwb_flush  = ctrl_s.mwb_flush;
    assign halt       = ctrl_s.halt;

`ifdef HAZARD_PERF_EN
    logic              active_s;
    logic              stall_inc_s;
    logic              flush_inc_s;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Counting is only live while the pipeline runs or waits on memory.
    always_comb begin
        active_s    = (state_q == RUN) || (state_q == MEM_WAIT);
        stall_inc_s = active_s && !ctrl_s.pc_en;
        flush_inc_s = active_s && (ctrl_s == CTRL_REDIRECT);
    end

    // Saturating stall and redirect-flush counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc_s && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flush_inc_s && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-latch enable and flush signals for four cases: load-use bubbles, data-memory wait freezes, taken-branch/jump flushes, and instruction-fetch misses.
- Runs a halt-drain sequence.
- Works alongside the forwarding unit. Forwarding resolves ALU-to-ALU hazards; this block resolves only what forwarding cannot.

Parameters:
- DRAIN_CYCLES, 2: cycles between halt detection in EX/MEM and assertion of halt.
- PERF_W, 32: width of performance counters (optional feature only).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising CLK.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- ifid_rs  in  5  rs of instruction in IF/ID.
- ifid_rt  in  5  rt of instruction in IF/ID.
- ifid_rt_used  in  1  IF/ID instruction reads rt as a source.
- idex_dREN  in  1  ID/EX instruction is a load.
- idex_wsel  in  5  destination register of ID/EX instruction.
- exm_dREN  in  1  EX/MEM instruction reads memory.
- exm_dWEN  in  1  EX/MEM instruction writes memory.
- exm_pc_redirect  in  1  EX/MEM holds a taken branch or jump.
- exm_halt  in  1  EX/MEM holds HALT.
- pc_en  out  1  PC register update enable.
- ifid_en, idex_en, exm_en, mwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exm_flush, mwb_flush  out  1 each  latch clear (bubble insert).
- halt  out  1  processor halted; sticky.

Behaviour:
- State (cpu_types_pkg::hzd_state_t): IDLE, RUN, MEM_WAIT, DRAIN, HALTED. Registered.
- Outputs are combinational from current state and inputs.
- Reset: nRST low at a rising edge sets state=IDLE and drain counter=0.
- IDLE outputs: all enables 0, all flushes 1, halt 0. IDLE always goes to RUN on the next edge.
- RUN priority, highest first:
  1. exm_halt: exm_en=0, mwb_en=1, pc_en=0, ifid_flush=idex_flush=1. Next state DRAIN, counter=0.
  2. (exm_dREN|exm_dWEN)&!dhit: pc_en=ifid_en=idex_en=exm_en=0, mwb_en=1, mwb_flush=1. Next state MEM_WAIT.
  3. exm_pc_redirect: pc_en=1, ifid_flush=idex_flush=exm_flush=1, mwb_en=1. Flush overrides ihit=0; the pending fetch is abandoned.
  4. Load-use: idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | (ifid_rt_used & idex_wsel==ifid_rt)). pc_en=ifid_en=0, idex_flush=1, exm_en=mwb_en=1. Exactly one bubble per load.
  5. !ihit: pc_en=0, ifid_flush=1, idex_en=exm_en=mwb_en=1.
  6. Otherwise all enables 1, all flushes 0.
  - Stall and flush on the same latch: flush wins.
- MEM_WAIT: same outputs as RUN rule 2 while dhit=0.
  - When dhit=1, outputs are RUN evaluation with rule 2 masked; next state RUN.
  - A redirect or halt arriving in EX/MEM is held frozen until the memory access completes.
- DRAIN: pc_en, ifid_en, idex_en, exm_en = 0; mwb_en=1; exm_flush=1. Counter increments each cycle.
  - When counter==DRAIN_CYCLES-1, next state is HALTED.
  - dhit is ignored in this state.
- HALTED: all enables 0, halt=1. Leaves only through reset.
- Reset is honoured in every state, mid-stall included. No partial output persists past the reset edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt[PERF_W] and flush_cnt[PERF_W].
  - stall_cnt increments on any cycle with pc_en=0 in RUN or MEM_WAIT.
  - flush_cnt increments on each RUN-rule-3 cycle.
  - Both counters saturate at all-ones, clear on reset, and freeze in DRAIN and HALTED.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg gets regbits_t (5 bits) and hzd_state_t enum (3-bit encoding).
- Sub-module load_use_detect: combinational compare of idex_dREN, idex_wsel, ifid_rs, ifid_rt, ifid_rt_used, producing lu_hazard. Instantiated once.

Test Plan:
- Reset, then release with ihit=1: cycle after release all flushes=1 and enables=0; next cycle all enables=1, flushes=0.
- Load-use: idex_dREN=1, idex_wsel=8, ifid_rs=8 → one cycle with pc_en=0, ifid_en=0, idex_flush=1. idex_wsel=0 gives no stall. ifid_rt=8 with ifid_rt_used=0 gives no stall.
- Memory wait: exm_dREN=1 with dhit=0 for 3 cycles → 3 cycles of frozen front, mwb_flush=1. dhit=1 on the 4th cycle returns to all enables=1.
- Redirect during dmem wait: exm_pc_redirect=1, exm_dWEN=1, dhit=0 for 2 cycles → frozen, no flush. On dhit=1: pc_en=1 and ifid/idex/exm flush=1.
- Redirect with ihit=0 and a load-use hazard in the same cycle → redirect outputs only.
- Halt with DRAIN_CYCLES=2: exm_halt=1 → DRAIN for 2 cycles, then halt=1, sticky across 10 cycles. nRST low for one edge clears halt.
